// File: rtl/tpg_pkg.sv
// Shared definitions for the test pattern generator: mode encodings, the RGB332
// pixel layout and the colour lookups used by the pattern mux.
package tpg_pkg;

    // Pattern selector encodings (mode_in / mode)
    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_GRAY  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_CYCLE = 2'd3;

    // RGB332 pixel: blue in the top two bits, then green, then red
    typedef struct packed {
        logic [1:0] b;
        logic [2:0] g;
        logic [2:0] r;
    } rgb332_t;

    localparam rgb332_t RGB_WHITE = '{b: 2'b11, g: 3'b111, r: 3'b111};
    localparam rgb332_t RGB_BLACK = '{b: 2'b00, g: 3'b000, r: 3'b000};

    // Colour-bar lookup: white, yellow, cyan, green, magenta, red, blue, black
    function automatic rgb332_t bar_rgb(input logic [2:0] idx);
        rgb332_t c;
        c.r = idx[1] ? 3'b000 : 3'b111;
        c.g = idx[2] ? 3'b000 : 3'b111;
        c.b = idx[0] ? 2'b00  : 2'b11;
        return c;
    endfunction

    // Gray-step lookup: white at index 0 down to black at index 7
    function automatic rgb332_t gray_rgb(input logic [2:0] idx);
        rgb332_t c;
        c.r = ~idx;
        c.g = ~idx;
        c.b = ~idx[2:1];
        return c;
    endfunction

endpackage

// File: rtl/tpg_bar_tracker.sv
// Divider-free bar index tracker. Follows the active pixel stream and keeps
// bar_idx equal to floor(x / BAR_W), clamped to NUM_BARS-1, so any remainder
// pixels at the end of a line join the last bar.
//
// Ports:
//   pclk         pixel clock, rising edge
//   rst          synchronous active-high reset
//   active_video current pixel is visible; tracker holds when low
//   x            pixel column, 0 on the first active pixel of a line
//   bar_idx      registered bar index of the pixel sampled on the last edge
module tpg_bar_tracker #(
    parameter int unsigned BAR_W    = 75,
    parameter int unsigned NUM_BARS = 8,
    parameter int unsigned X_W      = 10
) (
    input  logic           pclk,
    input  logic           rst,
    input  logic           active_video,
    input  logic [X_W-1:0] x,
    output logic [2:0]     bar_idx
);

    localparam int unsigned      POS_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(BAR_W - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_BARS - 1);

    logic [POS_W-1:0] bar_pos;

    // Position within the current bar; x == 0 restarts regardless of history
    always_ff @(posedge pclk) begin
        if (rst) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (active_video) begin
            if (x == '0) begin
                bar_pos <= '0;
                bar_idx <= '0;
            end else if (bar_pos == POS_LAST) begin
                bar_pos <= '0;
                if (bar_idx != IDX_LAST) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_pos <= bar_pos + POS_W'(1);
            end
        end
    end

endmodule

// File: rtl/test_pattern_gen.sv
// Pipelined RGB332 test pattern source between the NTSC timing generator and
// the DAC/encoder. Four patterns: colour bars, gray steps, checkerboard and a
// frame-animated solid colour. The pattern select is shadowed on frame_start so
// a switch never tears mid-frame. Latency from x/y/active_video to rgb is 2 pclk.
//
// Ports:
//   pclk         pixel clock, rising edge
//   rst          synchronous active-high reset
//   x, y         pixel column / row from the timing generator
//   active_video x/y is inside the visible area
//   frame_start  one-cycle pulse ahead of the first active pixel of a frame
//   mode_in      requested pattern, sampled only on frame_start
//   rgb          RGB332 pixel ({b[1:0], g[2:0], r[2:0]}), 0 during blanking
//   rgb_valid    rgb belongs to an active pixel
//   mode         pattern currently in effect
module test_pattern_gen
    import tpg_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 600,
    parameter int unsigned V_ACTIVE   = 450,
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 9,
    parameter int unsigned NUM_BARS   = 8,
    parameter int unsigned CHECK_LOG2 = 5,
    parameter int unsigned FRAME_DIV  = 4
) (
    input  logic           pclk,
    input  logic           rst,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic           active_video,
    input  logic           frame_start,
    input  logic [1:0]     mode_in,
    output logic [7:0]     rgb,
    output logic           rgb_valid,
    output logic [1:0]     mode
);

    localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;
    localparam int unsigned FC_W  = FRAME_DIV + 3;

    logic [FC_W-1:0] frame_cnt;

    // Stage-1 registers (bar index lives inside the tracker)
    logic       s1_active;
    logic [1:0] s1_mode;
    logic       s1_x_bit;
    logic       s1_y_bit;
    logic [2:0] s1_bar_idx;
    logic [2:0] s1_cycle_idx;

    rgb332_t    pix_c;

    // Mode shadow and frame counter; counter wraps naturally
    always_ff @(posedge pclk) begin
        if (rst) begin
            mode      <= MODE_BARS;
            frame_cnt <= '0;
        end else if (frame_start) begin
            mode      <= mode_in;
            frame_cnt <= frame_cnt + FC_W'(1);
        end
    end

    tpg_bar_tracker #(
        .BAR_W    (BAR_W),
        .NUM_BARS (NUM_BARS),
        .X_W      (X_W)
    ) u_bar_tracker (
        .pclk         (pclk),
        .rst          (rst),
        .active_video (active_video),
        .x            (x),
        .bar_idx      (s1_bar_idx)
    );

    // Stage 1: capture pixel context; mode/frame_cnt are the pre-update values
    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_active    <= 1'b0;
            s1_mode      <= MODE_BARS;
            s1_x_bit     <= 1'b0;
            s1_y_bit     <= 1'b0;
            s1_cycle_idx <= 3'd0;
        end else begin
            s1_active    <= active_video;
            s1_mode      <= mode;
            s1_x_bit     <= x[CHECK_LOG2];
            s1_y_bit     <= y[CHECK_LOG2];
            s1_cycle_idx <= frame_cnt[FC_W-1:FRAME_DIV];
        end
    end

    // Pattern mux
    always_comb begin
        pix_c = RGB_BLACK;
        case (s1_mode)
            MODE_BARS:  pix_c = bar_rgb(s1_bar_idx);
            MODE_GRAY:  pix_c = gray_rgb(s1_bar_idx);
            MODE_CHECK: pix_c = (s1_x_bit ^ s1_y_bit) ? RGB_WHITE : RGB_BLACK;
            MODE_CYCLE: pix_c = bar_rgb(s1_cycle_idx);
            default:    pix_c = RGB_BLACK;
        endcase
    end

    // Stage 2: registered output, forced to zero during blanking
    always_ff @(posedge pclk) begin
        if (rst || !s1_active) begin
            rgb       <= 8'h00;
            rgb_valid <= 1'b0;
        end else begin
            rgb       <= pix_c;
            rgb_valid <= 1'b1;
        end
    end

    // Visible rows are expected to stay inside the frame height
    y_in_frame_a: assert property (@(posedge pclk) disable iff (rst)
        active_video |-> (32'(y) < V_ACTIVE));

endmodule
